// File: rtl/pc_fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller:
// state encoding, default vectors and redirect-priority selection.
package pc_fetch_controller_pkg;

    localparam int          SIZE             = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2,
        REDIR_EXC    = 2'd3
    } redir_sel_e;

    // Exception beats jump, jump beats branch.
    function automatic redir_sel_e redirSelect(input logic exc, input logic jmp, input logic br);
        if (exc)      return REDIR_EXC;
        else if (jmp) return REDIR_JUMP;
        else if (br)  return REDIR_BRANCH;
        else          return REDIR_NONE;
    endfunction

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_controller_if.sv
// Fetch-side bundle: redirect controls, instruction memory port and the
// IF/ID hand-off. The controller uses master; its environment uses slave.
interface pc_fetch_controller_if;
    import pc_fetch_controller_pkg::*;

    logic            stall;
    logic            branch_taken;
    logic [SIZE-1:0] branch_target;
    logic            jump;
    logic [SIZE-1:0] jump_target;
    logic            exception;
    logic            imem_req;
    logic [SIZE-1:0] imem_addr;
    logic            imem_ready;
    logic [SIZE-1:0] imem_rdata;
    logic            instr_valid;
    logic [SIZE-1:0] instr;
    logic [SIZE-1:0] instr_pc;
    logic [SIZE-1:0] pc_plus4;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, exception,
        input  imem_ready, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, exception,
        output imem_ready, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4
    );

endinterface

// File: rtl/pc_fetch_controller_pc_incr.sv
// Word-step incrementer; wraps modulo 2^SIZE with no carry out.
module pc_incr #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] in_i,
    output logic [SIZE-1:0] out_o
);

    assign out_o = in_i + SIZE'(4);

endmodule

// File: rtl/pc_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding imem
// request at a time, holds the fetched word for decode and applies redirects.
module pc_fetch_controller
    import pc_fetch_controller_pkg::*;
#(
    parameter int          SIZE         = 32,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pc_fetch_controller_if.master   fif
);

    fetch_state_e    state_q, state_d;
    logic [SIZE-1:0] pc_q, pc_d;
    logic [SIZE-1:0] pend_q, pend_d;
    logic [SIZE-1:0] instr_q, instr_d;
    logic [SIZE-1:0] ipc_q, ipc_d;
    logic            req_q, req_d;

    logic [SIZE-1:0] pcNext;
    logic [SIZE-1:0] pcPlus4;
    logic [SIZE-1:0] target;
    redir_sel_e      redirSel;
    logic            redirect;
    logic            memAck;

    pc_incr #(.SIZE(SIZE)) u_next_pc (.in_i(pc_q),  .out_o(pcNext));
    pc_incr #(.SIZE(SIZE)) u_link_pc (.in_i(ipc_q), .out_o(pcPlus4));

    assign redirSel = redirSelect(fif.exception, fif.jump, fif.branch_taken);
    assign redirect = (redirSel != REDIR_NONE);

    always_comb begin
        target = '0;
        case (redirSel)
            REDIR_EXC:    target = alignWord(EXC_VECTOR);
            REDIR_JUMP:   target = alignWord(fif.jump_target);
            REDIR_BRANCH: target = alignWord(fif.branch_target);
            default:      target = '0;
        endcase
    end

    // A response only counts while our request is actually on the bus.
    assign memAck = fif.imem_ready & req_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        case (state_q)
            FETCH: begin
                if (memAck && !redirect) begin
                    instr_d = fif.imem_rdata;
                    ipc_d   = pc_q;
                    pc_d    = pcNext;
                    state_d = HOLD;
                end else if (memAck) begin
                    pc_d = target;
                end else if (redirect) begin
                    // Nothing in flight yet (first cycle out of reset): retarget directly.
                    if (req_q) begin
                        pend_d  = target;
                        state_d = FLUSH;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!fif.stall) begin
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    pend_d = target;
                end
                if (memAck) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        req_d = (state_d != HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            req_q   <= req_d;
        end
    end

    assign fif.imem_req    = req_q;
    assign fif.imem_addr   = pc_q;
    assign fif.instr_valid = (state_q == HOLD);
    assign fif.instr       = instr_q;
    assign fif.instr_pc    = ipc_q;
    assign fif.pc_plus4    = pcPlus4;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed vector bench for pc_fetch_controller: a table of per-cycle
// inputs with hand-computed registered outputs, then a back-to-back fetch run.
module tb_pc_fetch_controller;
    import pc_fetch_controller_pkg::*;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [31:0] brT;
        logic        jmp;
        logic [31:0] jT;
        logic        exc;
        logic        rdy;
        logic [31:0] rdata;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic [31:0] eP4;
    } vec_t;

    logic clk;
    logic rst_n;
    int   nApplied;
    int   nMiscompares;
    vec_t vecs[$];

    pc_fetch_controller_if fif ();

    pc_fetch_controller #(
        .SIZE        (32),
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR  (32'h8000_0180)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fif  (fif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t V(
        input logic rst_n_v, input logic stall, input logic br, input logic [31:0] brT,
        input logic jmp, input logic [31:0] jT, input logic exc, input logic rdy,
        input logic [31:0] rdata, input logic eReq, input logic [31:0] eAddr,
        input logic eValid, input logic [31:0] eInstr, input logic [31:0] ePc,
        input logic [31:0] eP4);
        vec_t v;
        v.rst_n = rst_n_v; v.stall = stall; v.br = br; v.brT = brT;
        v.jmp = jmp; v.jT = jT; v.exc = exc; v.rdy = rdy; v.rdata = rdata;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid;
        v.eInstr = eInstr; v.ePc = ePc; v.eP4 = eP4;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n             = v.rst_n;
        fif.stall         = v.stall;
        fif.branch_taken  = v.br;
        fif.branch_target = v.brT;
        fif.jump          = v.jmp;
        fif.jump_target   = v.jT;
        fif.exception     = v.exc;
        fif.imem_ready    = v.rdy;
        fif.imem_rdata    = v.rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL v%0d %s: got %h, expected %h", idx, name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkField("imem_req",    idx, {31'd0, fif.imem_req},    {31'd0, v.eReq});
        checkField("imem_addr",   idx, fif.imem_addr,            v.eAddr);
        checkField("instr_valid", idx, {31'd0, fif.instr_valid}, {31'd0, v.eValid});
        checkField("instr",       idx, fif.instr,                v.eInstr);
        checkField("instr_pc",    idx, fif.instr_pc,             v.ePc);
        checkField("pc_plus4",    idx, fif.pc_plus4,             v.eP4);
    endtask

    initial begin
        logic [31:0] modelPc;
        nApplied     = 0;
        nMiscompares = 0;
        rst_n = 1'b0;
        fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = '0;
        fif.jump = 1'b0; fif.jump_target = '0; fif.exception = 1'b0;
        fif.imem_ready = 1'b0; fif.imem_rdata = '0;

        //             rst st br brT           jmp jT            exc rdy rdata          req addr          vld instr          ipc            p4
        vecs.push_back(V(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        32'h4));
        vecs.push_back(V(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        32'h4));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hA0,        1, 32'h0,        0, 32'h0,        32'h0,        32'h4));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h11,        0, 32'h4,        1, 32'h11,       32'h0,        32'h4));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         1, 32'h4,        0, 32'h11,       32'h0,        32'h4));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h22,        0, 32'h8,        1, 32'h22,       32'h4,        32'h8));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         1, 32'h8,        0, 32'h22,       32'h4,        32'h8));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h2108_0001, 0, 32'hC,        1, 32'h2108_0001, 32'h8,       32'hC));
        // stall three cycles in HOLD
        vecs.push_back(V(1, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         0, 32'hC,        1, 32'h2108_0001, 32'h8,       32'hC));
        vecs.push_back(V(1, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         0, 32'hC,        1, 32'h2108_0001, 32'h8,       32'hC));
        vecs.push_back(V(1, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         0, 32'hC,        1, 32'h2108_0001, 32'h8,       32'hC));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         1, 32'hC,        0, 32'h2108_0001, 32'h8,       32'hC));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h33,        0, 32'h10,       1, 32'h33,       32'hC,        32'h10));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         1, 32'h10,       0, 32'h33,       32'hC,        32'h10));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h44,        0, 32'h14,       1, 32'h44,       32'h10,       32'h14));
        // branch in HOLD while stalled, target 0x42 aligns to 0x40
        vecs.push_back(V(1, 1, 1, 32'h42,       0, 32'h0,        0, 1, 32'h0,         1, 32'h40,       0, 32'h44,       32'h10,       32'h14));
        // ready and jump together: word dropped, PC retargeted
        vecs.push_back(V(1, 0, 0, 32'h0,        1, 32'h20,       0, 1, 32'h55,        1, 32'h20,       0, 32'h44,       32'h10,       32'h14));
        // jump while the fetch of 0x20 waits: FLUSH keeps the address stable
        vecs.push_back(V(1, 0, 0, 32'h0,        1, 32'h100,      0, 0, 32'h0,         1, 32'h20,       0, 32'h44,       32'h10,       32'h14));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,         1, 32'h20,       0, 32'h44,       32'h10,       32'h14));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,         1, 32'h20,       0, 32'h44,       32'h10,       32'h14));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hDEAD_BEEF, 1, 32'h100,      0, 32'h44,       32'h10,       32'h14));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h66,        0, 32'h104,      1, 32'h66,       32'h100,      32'h104));
        // all three redirects at once: exception wins
        vecs.push_back(V(1, 0, 1, 32'h300,      1, 32'h200,      1, 0, 32'h0,         1, 32'h8000_0180, 0, 32'h66,      32'h100,      32'h104));
        // FLUSH: latest pending target wins, same-cycle redirect beats pending
        vecs.push_back(V(1, 0, 1, 32'h501,      0, 32'h0,        0, 0, 32'h0,         1, 32'h8000_0180, 0, 32'h66,      32'h100,      32'h104));
        vecs.push_back(V(1, 0, 0, 32'h0,        1, 32'h600,      0, 0, 32'h0,         1, 32'h8000_0180, 0, 32'h66,      32'h100,      32'h104));
        vecs.push_back(V(1, 0, 1, 32'h703,      0, 32'h0,        0, 1, 32'hBAD,       1, 32'h700,      0, 32'h66,       32'h100,      32'h104));
        vecs.push_back(V(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,         1, 32'h700,      0, 32'h66,       32'h100,      32'h104));
        // wrap: fetch at 0xFFFF_FFFC
        vecs.push_back(V(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFF, 0, 1, 32'h77,       1, 32'hFFFF_FFFC, 0, 32'h66,      32'h100,      32'h104));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h88,        0, 32'h0,        1, 32'h88,       32'hFFFF_FFFC, 32'h0));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         1, 32'h0,        0, 32'h88,       32'hFFFF_FFFC, 32'h0));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h99,        0, 32'h4,        1, 32'h99,       32'h0,        32'h4));
        // reset mid-operation
        vecs.push_back(V(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,        32'h4));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        32'h4));
        // jump beats branch
        vecs.push_back(V(1, 0, 1, 32'h5678,     1, 32'h1234,     0, 0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0,        32'h4));
        vecs.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hAA,        1, 32'h1234,     0, 32'h0,        32'h0,        32'h4));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Zero-wait back-to-back fetches: one instruction every two cycles.
        modelPc = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            vec_t v;
            logic [31:0] word;
            word = 32'hC000_0000 | i;
            v = V(1, 0, 0, 32'h0, 0, 32'h0, 0, 1, word,
                  0, modelPc + 32'd4, 1, word, modelPc, modelPc + 32'd4);
            applyStimulus(v);
            checkOutput(v, 100 + 2 * i);
            v = V(1, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0,
                  1, modelPc + 32'd4, 0, word, modelPc, modelPc + 32'd4);
            applyStimulus(v);
            checkOutput(v, 101 + 2 * i);
            modelPc = modelPc + 32'd4;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end

endmodule
